// File: rtl/if_addr_gen_if.sv
// Read-beat bus between the IF address generator and the IF buffer / systolic feeder.
// A beat transfers on a cycle where rd_en and rd_ready are both high.
interface if_addr_gen_if #(
    parameter int ADDR_W = 16
) ();
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              rd_last;
    logic              rd_ready;

    modport master (
        output rd_addr,
        output rd_en,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_addr,
        input  rd_en,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/if_addr_gen.sv
// IF read address generator: sweeps a rows x cols tile with an arbitrary row pitch,
// issuing one registered read address per beat over the rd_* valid/ready bus.
module if_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read,
    input  logic              clr_if,
    output logic              if_done,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_pitch,
    input  logic [DIM_W-1:0]  cfg_rows,
    input  logic [DIM_W-1:0]  cfg_cols,
    if_addr_gen_if.master     rd,
    output logic              busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] pitch_q;
    logic [ADDR_W-1:0] row_base;
    logic [DIM_W-1:0]  rows_m1;
    logic [DIM_W-1:0]  cols_m1;
    logic [DIM_W-1:0]  row_cnt;
    logic [DIM_W-1:0]  col_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              en_q;
    logic              last_q;

    logic              start;
    logic              dims_ok;
    logic              first_last;
    logic              accept;
    logic              at_col_end;
    logic              at_row_end;
    logic              at_last;
    logic [ADDR_W-1:0] next_row_base;
    logic [ADDR_W-1:0] adv_addr;
    logic [DIM_W-1:0]  adv_row;
    logic [DIM_W-1:0]  adv_col;
    logic              adv_last;

    assign start      = if_read & clr_if;
    assign dims_ok    = (cfg_rows != '0) && (cfg_cols != '0);
    assign first_last = (cfg_rows == DIM_W'(1)) && (cfg_cols == DIM_W'(1));
    assign accept     = en_q & rd.rd_ready;

    // Counters always name the beat on the bus, or the next beat to present while rd_en=0.
    always_comb begin
        at_col_end    = (col_cnt == cols_m1);
        at_row_end    = (row_cnt == rows_m1);
        at_last       = at_col_end & at_row_end;
        next_row_base = row_base + pitch_q;
        if (at_col_end) begin
            adv_addr = next_row_base;
            adv_col  = '0;
            adv_row  = row_cnt + DIM_W'(1);
        end else begin
            adv_addr = addr_q + ADDR_W'(1);
            adv_col  = col_cnt + DIM_W'(1);
            adv_row  = row_cnt;
        end
        adv_last = (adv_row == rows_m1) && (adv_col == cols_m1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pitch_q  <= '0;
            row_base <= '0;
            rows_m1  <= '0;
            cols_m1  <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            addr_q   <= '0;
            en_q     <= 1'b0;
            last_q   <= 1'b0;
            if_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (start) begin
                        // A restart from RUN drops the pending beat for one cycle before the new first beat.
                        pitch_q  <= cfg_pitch;
                        rows_m1  <= cfg_rows - DIM_W'(1);
                        cols_m1  <= cfg_cols - DIM_W'(1);
                        row_base <= cfg_base;
                        addr_q   <= cfg_base;
                        row_cnt  <= '0;
                        col_cnt  <= '0;
                        busy     <= 1'b1;
                        en_q     <= dims_ok && (state == IDLE);
                        last_q   <= dims_ok && (state == IDLE) && first_last;
                        if (dims_ok) begin
                            state   <= RUN;
                            if_done <= 1'b0;
                        end else begin
                            state   <= DRAIN;
                            if_done <= 1'b1;
                        end
                    end else if (state == RUN) begin
                        if (accept) begin
                            if (last_q) begin
                                state   <= DRAIN;
                                en_q    <= 1'b0;
                                last_q  <= 1'b0;
                                if_done <= 1'b1;
                            end else begin
                                addr_q  <= adv_addr;
                                col_cnt <= adv_col;
                                row_cnt <= adv_row;
                                if (at_col_end) begin
                                    row_base <= next_row_base;
                                end
                                en_q   <= if_read;
                                last_q <= if_read & adv_last;
                            end
                        end else if (!en_q && if_read) begin
                            en_q   <= 1'b1;
                            last_q <= at_last;
                        end
                    end
                end
                DRAIN: begin
                    state   <= IDLE;
                    if_done <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    en_q    <= 1'b0;
                    last_q  <= 1'b0;
                    if_done <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign rd.rd_addr = addr_q;
    assign rd.rd_en   = en_q;
    assign rd.rd_last = last_q;

endmodule

// File: tb/tb_if_addr_gen.sv
// Directed self-checking bench for if_addr_gen: sweeps, backpressure, wrap, zero-size,
// pause, restart and asynchronous reset, with hand-computed address sequences.
module tb_if_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_read = 1'b0;
    logic        clr_if = 1'b0;
    logic        if_done;
    logic [15:0] cfg_base = '0;
    logic [15:0] cfg_pitch = '0;
    logic [7:0]  cfg_rows = '0;
    logic [7:0]  cfg_cols = '0;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_a [0:15];

    if_addr_gen_if #(.ADDR_W(16)) bus ();

    if_addr_gen #(.ADDR_W(16), .DIM_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_read  (if_read),
        .clr_if   (clr_if),
        .if_done  (if_done),
        .cfg_base (cfg_base),
        .cfg_pitch(cfg_pitch),
        .cfg_rows (cfg_rows),
        .cfg_cols (cfg_cols),
        .rd       (bus.master),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start, then scramble the config to show it is not re-sampled.
    task automatic start(input logic [15:0] b, input logic [15:0] p,
                         input logic [7:0] r, input logic [7:0] c);
        cfg_base  = b;
        cfg_pitch = p;
        cfg_rows  = r;
        cfg_cols  = c;
        if_read   = 1'b1;
        clr_if    = 1'b1;
        step();
        clr_if    = 1'b0;
        cfg_base  = 16'hDEAD;
        cfg_pitch = 16'h0777;
        cfg_rows  = 8'd9;
        cfg_cols  = 8'd9;
    endtask

    // Follow a sweep of n beats against exp_a; mode 1 applies rd_ready pattern 1,0,0 repeating.
    task automatic sweep(input int n, input int mode, input int budget);
        int   idx = 0;
        int   last_acc = -1;
        int   done_cnt = 0;
        int   done_cyc = -100;
        logic rdy;
        for (int cyc = 0; cyc < budget; cyc++) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            bus.rd_ready = rdy;
            if (cyc == 0 && n > 0) check("first_en", int'(bus.rd_en), 1);
            if (bus.rd_en) begin
                if (idx < n) begin
                    check("addr", int'(bus.rd_addr), int'(exp_a[idx]));
                    check("last", int'(bus.rd_last), int'(idx == n - 1));
                    if (rdy) begin
                        if (idx == n - 1) last_acc = cyc;
                        idx++;
                    end
                end else begin
                    check("extra_beat", int'(bus.rd_en), 0);
                end
            end
            if (if_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            step();
        end
        bus.rd_ready = 1'b1;
        check("accepts", idx, n);
        check("done_cnt", done_cnt, 1);
        check("done_time", done_cyc, last_acc + 1);
        check("busy_end", int'(busy), 0);
    endtask

    initial begin
        bus.rd_ready = 1'b1;
        #2;
        check("rst_en", int'(bus.rd_en), 0);
        check("rst_last", int'(bus.rd_last), 0);
        check("rst_addr", int'(bus.rd_addr), 0);
        check("rst_done", int'(if_done), 0);
        check("rst_busy", int'(busy), 0);
        step();
        rst = 1'b0;
        step();

        // Basic sweep; if_read held high through and after if_done must not restart.
        exp_a[0] = 16'h100; exp_a[1] = 16'h101; exp_a[2] = 16'h102;
        exp_a[3] = 16'h120; exp_a[4] = 16'h121; exp_a[5] = 16'h122;
        start(16'h100, 16'h20, 8'd2, 8'd3);
        check("busy_run", int'(busy), 1);
        sweep(6, 0, 12);
        if_read = 1'b0;
        step();

        // Backpressure with the same tile.
        start(16'h100, 16'h20, 8'd2, 8'd3);
        sweep(6, 1, 24);
        if_read = 1'b0;
        step();

        // Address wrap modulo 2^16.
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
        exp_a[3] = 16'h000E; exp_a[4] = 16'h000F; exp_a[5] = 16'h0010;
        start(16'hFFFE, 16'h10, 8'd2, 8'd3);
        sweep(6, 0, 12);
        if_read = 1'b0;
        step();

        // Zero rows: no beats, if_done right after start.
        start(16'h300, 16'h10, 8'd0, 8'd4);
        sweep(0, 0, 5);
        if_read = 1'b0;
        step();

        // Pause after the 2nd accept, then resume at the 3rd address.
        start(16'h100, 16'h20, 8'd2, 8'd3);
        check("p_addr0", int'(bus.rd_addr), 16'h100);
        step();
        check("p_addr1", int'(bus.rd_addr), 16'h101);
        if_read = 1'b0;
        step();
        check("p_en_off0", int'(bus.rd_en), 0);
        step();
        check("p_en_off1", int'(bus.rd_en), 0);
        check("p_busy", int'(busy), 1);
        if_read = 1'b1;
        step();
        exp_a[0] = 16'h102; exp_a[1] = 16'h120; exp_a[2] = 16'h121; exp_a[3] = 16'h122;
        sweep(4, 0, 10);
        if_read = 1'b0;
        step();

        // Restart during beat 4 of a 4x4 sweep.
        start(16'h300, 16'h10, 8'd4, 8'd4);
        step();
        step();
        step();
        check("r_beat4", int'(bus.rd_addr), 16'h303);
        cfg_base = 16'h200; cfg_pitch = 16'h40; cfg_rows = 8'd2; cfg_cols = 8'd2;
        clr_if = 1'b1;
        step();
        clr_if = 1'b0;
        check("r_gap_en", int'(bus.rd_en), 0);
        check("r_gap_done", int'(if_done), 0);
        step();
        exp_a[0] = 16'h200; exp_a[1] = 16'h201; exp_a[2] = 16'h240; exp_a[3] = 16'h241;
        sweep(4, 0, 10);
        if_read = 1'b0;
        step();

        // Restart coinciding with acceptance of the last beat: no if_done for the old sweep.
        start(16'h050, 16'h10, 8'd1, 8'd2);
        step();
        check("c_last", int'(bus.rd_last), 1);
        cfg_base = 16'h060; cfg_pitch = 16'h10; cfg_rows = 8'd1; cfg_cols = 8'd1;
        clr_if = 1'b1;
        step();
        clr_if = 1'b0;
        check("c_done", int'(if_done), 0);
        check("c_gap_en", int'(bus.rd_en), 0);
        step();
        exp_a[0] = 16'h060;
        sweep(1, 0, 6);
        if_read = 1'b0;
        step();

        // Asynchronous reset mid-sweep, then a clean start.
        start(16'h400, 16'h10, 8'd3, 8'd3);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("ar_en", int'(bus.rd_en), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_addr", int'(bus.rd_addr), 0);
        if_read = 1'b0;
        step();
        rst = 1'b0;
        step();
        exp_a[0] = 16'h500; exp_a[1] = 16'h501;
        start(16'h500, 16'h10, 8'd1, 8'd2);
        sweep(2, 0, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_addr_gen.md
Name: if_addr_gen

Overview:
- Input-feature (IF) read address generator. Sits directly downstream of the IF read controller: it consumes that controller's if_read / clr_if and returns if_done.
- Sweeps a rectangular IF tile (rows x cols, arbitrary row pitch) out of the IF buffer.
- Issues one read address per beat over a valid/ready handshake toward the IF buffer / systolic feeder.

Parameters:
- ADDR_W, 16, width of buffer read address and base/pitch config.
- DIM_W, 8, width of the row/column count config and internal counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- if_read  in  1  from controller; high = sweep may proceed.
- clr_if  in  1  from controller; sampled only when if_read=1. if_read&clr_if = start/restart sweep and latch config.
- if_done  out  1  one-cycle pulse: sweep complete.
- cfg_base  in  ADDR_W  tile start address.
- cfg_pitch  in  ADDR_W  address increment between rows.
- cfg_rows  in  DIM_W  number of rows.
- cfg_cols  in  DIM_W  beats (words) per row.
- rd_addr  out  ADDR_W  buffer read address.
- rd_en  out  1  beat valid.
- rd_last  out  1  qualifies the final beat of the tile.
- rd_ready  in  1  buffer/feeder accepts beat when rd_en&rd_ready.
- busy  out  1  high in RUN and DRAIN.

Behaviour:
- Reset (async assert, sync release) outputs: if_done=0, rd_en=0, rd_last=0, rd_addr=0, busy=0. State goes to IDLE; counters and latched config are cleared.
- All outputs are registered. Config is sampled only on a start (if_read&clr_if); changes at any other time are ignored.
- State machine:
  - IDLE -> RUN on start with cfg_rows!=0 and cfg_cols!=0.
  - IDLE -> DRAIN on start with a zero dimension. No beats are issued; if_done pulses the following cycle.
  - RUN -> DRAIN when the beat with rd_last=1 is accepted.
  - DRAIN -> IDLE unconditionally after one cycle, in which if_done=1.
- In IDLE/DRAIN, if_read without clr_if is ignored. The controller may hold if_read one cycle past if_done; this must not start a new sweep.
- Start latency: the cycle after start, rd_en=1 and rd_addr=cfg_base.
- Handshake:
  - A beat is held (rd_addr, rd_last stable, rd_en=1) until rd_ready=1.
  - On acceptance, the next beat is presented the very next cycle. Throughput is 1 beat/cycle with rd_ready tied high.
  - rd_en never drops while a beat is pending.
- Address sequence:
  - Row base starts at cfg_base. Within a row, addr increments by 1 for cols beats.
  - At row end, row base += cfg_pitch and the column counter resets.
  - There are no multipliers. All address arithmetic wraps modulo 2^ADDR_W.
- Beat count = rows*cols. rd_last=1 only on the beat with row=rows-1, col=cols-1.
- Pause: if if_read=0 in RUN, no new beat is issued after the current pending beat is accepted. rd_en goes 0 and position is held. When if_read returns high, the sweep resumes at the next position the cycle after.
- Restart: start during RUN aborts the sweep immediately.
  - A pending beat is dropped: rd_en=0 for exactly one cycle.
  - The new config is latched and the first beat follows as from IDLE.
  - No if_done is emitted for the aborted sweep.
- Simultaneous events:
  - Start in the same cycle as acceptance of the last beat: restart wins; no if_done for the old sweep.
  - rd_ready while rd_en=0 has no effect.
- Reset mid-sweep returns to IDLE immediately; outputs take reset values asynchronously.
- Max tile is (2^DIM_W-1)^2 beats. Counters are DIM_W wide and must not overflow at the max values.

Test Plan:
- Basic sweep: base=0x100, pitch=0x20, rows=2, cols=3, rd_ready=1.
  - Addrs 0x100,0x101,0x102,0x120,0x121,0x122 on consecutive cycles, starting the cycle after start.
  - rd_last on 0x122; if_done pulses the cycle after; busy falls with DRAIN exit.
- Backpressure: same config, rd_ready toggling 1,0,0,1,...
  - Each address is held stable while rd_ready=0; the sequence is unchanged; exactly 6 accepts, then 1 if_done.
- Wrap and zero:
  - base=0xFFFE, pitch=0x10, rows=2, cols=3 -> addrs FFFE,FFFF,0000,000E,000F,0010.
  - rows=0 -> no rd_en; if_done one cycle after start.
- Pause and trailing if_read:
  - Drop if_read after the 2nd accept -> rd_en=0, position held; re-raise -> resumes at the 3rd address.
  - Hold if_read=1, clr_if=0 for 1 cycle after if_done -> no new beats.
- Restart/reset:
  - Start with new base=0x200 during beat 4 of a rows=4/cols=4 sweep -> one rd_en=0 cycle, then 0x200...; exactly one if_done, at the end of the new sweep.
  - rst asserted mid-sweep -> rd_en/busy drop asynchronously; the next start begins cleanly.
